// File: rtl/fetch_buffer_pkg.sv
// Shared pipeline packet typedefs and fetch buffer sizing.
`ifndef FETCH_BUFFER_SIZE
`define FETCH_BUFFER_SIZE 8
`endif

package fetch_buffer_pkg;

    localparam int unsigned FB_DEPTH  = `FETCH_BUFFER_SIZE;
    localparam int unsigned XLEN      = 32;

    // One fetched instruction travelling from fetch to dispatch.
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] npc;
    } FETCH_PACKET;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch/dispatch side bundle of the fetch buffer.
interface fetch_buffer_if
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
);
    FETCH_PACKET   fetch_packet_in;
    logic          dispatch_stall;
    logic          squash;
    FETCH_PACKET   fetch_packet_out;
    logic          fb_full;
    logic [CW-1:0] fb_count;
    logic          fb_empty;

    // Fetch/dispatch/CDB side drives the buffer.
    modport master (
        output fetch_packet_in, dispatch_stall, squash,
        input  fetch_packet_out, fb_full, fb_count, fb_empty
    );

    // The buffer itself.
    modport slave (
        input  fetch_packet_in, dispatch_stall, squash,
        output fetch_packet_out, fb_full, fb_count, fb_empty
    );
endinterface

// File: rtl/fetch_buffer_ptr_ctrl.sv
// Head/tail/count bookkeeping and enq/deq/squash arbitration for the fetch buffer.
module fb_ptr_ctrl
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    input  logic          dispatch_stall,
    input  logic          squash,
    output logic [PW-1:0] head_ptr,
    output logic [PW-1:0] tail_ptr,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty,
    output logic          enq_c
);

    logic          deq_c;
    logic [CW-1:0] count_next;

    // Squash blocks both sides; full/empty come from registers, so no same-cycle bypass.
    always_comb begin
        enq_c      = in_valid & ~full & ~squash;
        deq_c      = ~empty & ~dispatch_stall & ~squash;
        count_next = count + CW'(enq_c) - CW'(deq_c);
    end

    // Pointer/count registers; pointers wrap naturally at DEPTH (power of two).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else if (squash) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
        end else begin
            if (enq_c) tail_ptr <= tail_ptr + PW'(1);
            if (deq_c) head_ptr <= head_ptr + PW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

endmodule

// File: rtl/fetch_buffer.sv
// In-order decoupling queue between fetch and dispatch, flushed on CDB squash.
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = FB_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic           clock,
    input  logic           reset,
    fetch_buffer_if.slave  bus
);

    FETCH_PACKET   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          enq_c;

    fb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (bus.fetch_packet_in.valid),
        .dispatch_stall (bus.dispatch_stall),
        .squash         (bus.squash),
        .head_ptr       (head_ptr),
        .tail_ptr       (tail_ptr),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .enq_c          (enq_c)
    );

    // Entry storage; only accepted packets are written at the tail.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (enq_c) begin
            mem[tail_ptr] <= bus.fetch_packet_in;
        end
    end

    // Head entry straight from the array; valid is qualified by occupancy.
    always_comb begin
        bus.fetch_packet_out       = mem[head_ptr];
        bus.fetch_packet_out.valid = ~empty;
    end

    assign bus.fb_full  = full;
    assign bus.fb_empty = empty;
    assign bus.fb_count = count;

endmodule
